// File: rtl/alu_mdu_seq.sv
// RV32-style integer unit: single-cycle base ALU ops plus M-extension mul/div behind valid/ready.
// Optional macro ALU_MDU_FAST_MUL_EN selects a single-cycle combinational multiplier.
module alu_mdu_seq #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [2:0]      func3,
    input  logic            opequal,
    input  logic            mext,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opb;
    logic [XLEN-1:0]     a_raw;
    logic [SHW-1:0]      count;
    logic [2:0]          op_f3;
    logic                res_neg;
    logic                rem_neg;
    logic                div_zero;

    function automatic logic [XLEN-1:0] alu_base(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                 input logic [2:0] f3, input logic alt);
        logic [XLEN-1:0] r;
        // NOTE: default assignment first so every path drives r and no latch is inferred.
        r = '0;
        case (f3)
            3'b000: r = alt ? a - b : a + b;
            3'b001: r = a << b[SHW-1:0];
            3'b010: r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            3'b011: r = {{(XLEN-1){1'b0}}, a < b};
            3'b100: r = a ^ b;
            3'b101: r = alt ? XLEN'($signed(a) >>> b[SHW-1:0]) : a >> b[SHW-1:0];
            3'b110: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // MUL keeps the low half of the signed product; the MULH variants keep the high half.
    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] mag, input logic neg,
                                                 input logic [1:0] sel);
        logic [2*XLEN-1:0] p;
        p = neg ? -mag : mag;
        return (sel == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    // Operand signedness: MULHU/DIVU/REMU unsigned, MULHSU has only rs1 signed.
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_signed = func3[2] ? ~func3[0] : (func3[1:0] != 2'b11);
    assign b_signed = func3[2] ? ~func3[0] : ~func3[1];
    assign a_neg    = a_signed & in1[XLEN-1];
    assign b_neg    = b_signed & in2[XLEN-1];
    assign a_mag    = a_neg ? -in1 : in1;
    assign b_mag    = b_neg ? -in2 : in2;

    // Shift-add multiply step: acc = {partial product high, remaining multiplier bits}.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc[XLEN-1:1]};

    // Restoring divide step: acc = {partial remainder, dividend bits / quotient bits}.
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] div_next;
    assign div_shift = acc[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opb};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0] step_next;
    logic [XLEN-1:0]   quo, rem, div_res, calc_res;
    assign step_next = op_f3[2] ? div_next : mul_next;
    assign quo       = step_next[XLEN-1:0];
    assign rem       = step_next[2*XLEN-1:XLEN];
    assign div_res   = div_zero ? (op_f3[1] ? a_raw : {XLEN{1'b1}})
                     : op_f3[1] ? (rem_neg ? -rem : rem)
                     : (res_neg ? -quo : quo);
    assign calc_res  = op_f3[2] ? div_res : mul_pick(step_next, res_neg, op_f3[1:0]);

`ifdef ALU_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    assign in_ready = (state == IDLE);

    // NOTE: all state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            count     <= '0;
            acc       <= '0;
            opb       <= '0;
            a_raw     <= '0;
            op_f3     <= '0;
            res_neg   <= 1'b0;
            rem_neg   <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!mext) begin
                            out       <= alu_base(in1, in2, func3, opequal);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
`ifdef ALU_MDU_FAST_MUL_EN
                        else if (!func3[2]) begin
                            out       <= mul_pick(fast_prod, a_neg ^ b_neg, func3[1:0]);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
`endif
                        else begin
                            op_f3    <= func3;
                            acc      <= {{XLEN{1'b0}}, func3[2] ? a_mag : b_mag};
                            opb      <= func3[2] ? b_mag : a_mag;
                            res_neg  <= a_neg ^ b_neg;
                            rem_neg  <= a_neg;
                            div_zero <= (in2 == '0);
                            a_raw    <= in1;
                            count    <= '0;
                            busy     <= 1'b1;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= step_next;
                    count <= count + 1'b1;
                    if (count == SHW'(XLEN-1)) begin
                        out       <= calc_res;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
